// File: rtl/pc_trace_if.sv
// Trace drain port of pc_trace_monitor: show-ahead FIFO head with a valid/ready handshake.
interface pc_trace_if;
  logic [31:0] trace_pc;
  logic        trace_vld;
  logic        trace_rdy;

  modport master (output trace_pc, output trace_vld, input trace_rdy);
  modport slave  (input trace_pc, input trace_vld, output trace_rdy);
endinterface

// File: rtl/pc_trace_monitor.sv
// Retirement observer: counts retires/cycles, detects a self-loop halt and buffers retired PCs.
// Optional macro PC_TRACE_DISCONT_ONLY_EN: trace only branch/jump targets (pc != prev_pc+4).
module pc_trace_monitor #(
  parameter  int TRACE_DEPTH = 16,
  parameter  int HALT_REPEAT = 4,
  parameter  int CNT_W       = 32,
  localparam int PTR_W       = $clog2(TRACE_DEPTH),
  localparam int LVL_W       = $clog2(TRACE_DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [31:0]      i_pc_debug,
  input  logic             i_insn_vld,
  output logic [CNT_W-1:0] o_retire_cnt,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic             o_halted,
  pc_trace_if.master       trace_if,
  output logic [LVL_W-1:0] o_trace_level,
  output logic             o_trace_ovf
);

  localparam int REP_W = $clog2(HALT_REPEAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_prev_pc;
  logic [REP_W-1:0] r_rep;
  logic [CNT_W-1:0] r_retire_cnt, r_cycle_cnt;
  logic [31:0]      r_mem [TRACE_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             r_ovf;

  logic w_active, w_match, w_halt_hit, w_filter;
  logic w_push_req, w_push, w_pop, w_full;

  assign w_active   = (r_state != S_HALTED);
  assign w_match    = (i_pc_debug == r_prev_pc);
  // >= rather than == so a match already counted in IDLE cannot skip past the threshold
  assign w_halt_hit = i_insn_vld && w_match && ((32'(r_rep) + 32'd1) >= 32'(HALT_REPEAT - 1));

`ifdef PC_TRACE_DISCONT_ONLY_EN
  logic r_seen;
  assign w_filter = !r_seen || (i_pc_debug != r_prev_pc + 32'd4);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)                    r_seen <= 1'b0;
    else if (i_insn_vld && w_active) r_seen <= 1'b1;
  end
`else
  assign w_filter = 1'b1;
`endif

  // NOTE: state register is pure flops with <=; all next-state decoding lives in always_comb
  // with its default assigned first so no latch can be inferred.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_insn_vld) w_state_nxt = S_RUN;
      S_RUN:    if (w_halt_hit) w_state_nxt = S_HALTED;
      S_HALTED: w_state_nxt = S_HALTED;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_prev_pc    <= '0;
      r_rep        <= '0;
      r_retire_cnt <= '0;
      r_cycle_cnt  <= '0;
    end else begin
      if (i_insn_vld && w_active) begin
        r_prev_pc <= i_pc_debug;
        r_rep     <= w_match ? r_rep + 1'b1 : '0;
        if (r_retire_cnt != '1) r_retire_cnt <= r_retire_cnt + 1'b1;
      end
      if ((r_state == S_RUN || (r_state == S_IDLE && i_insn_vld)) && r_cycle_cnt != '1)
        r_cycle_cnt <= r_cycle_cnt + 1'b1;
    end
  end

  assign w_full     = (r_level == LVL_W'(TRACE_DEPTH));
  assign w_push_req = i_insn_vld && w_active && w_filter;
  assign w_pop      = (r_level != '0) && trace_if.trace_rdy;
  assign w_push     = w_push_req && (!w_full || w_pop);

  // NOTE: the storage array has no reset; validity is carried entirely by r_level and the pointers.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_pc_debug;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_push && w_pop) r_level <= r_level - 1'b1;
      if (w_push_req && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  assign o_retire_cnt       = r_retire_cnt;
  assign o_cycle_cnt        = r_cycle_cnt;
  assign o_halted           = (r_state == S_HALTED);
  assign o_trace_level      = r_level;
  assign o_trace_ovf        = r_ovf;
  assign trace_if.trace_vld = (r_level != '0);
  assign trace_if.trace_pc  = (r_level != '0) ? r_mem[r_rd_ptr] : '0;

endmodule

// File: tb/tb_pc_trace_monitor.sv
// Directed self-checking bench for pc_trace_monitor (DEPTH=16, HALT_REPEAT=4, CNT_W=32).
module tb_pc_trace_monitor;
  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [31:0] i_pc_debug = '0;
  logic        i_insn_vld = 1'b0;
  logic [31:0] o_retire_cnt, o_cycle_cnt;
  logic        o_halted, o_trace_ovf;
  logic [4:0]  o_trace_level;
  int          n_checks = 0;
  int          n_fail = 0;

  pc_trace_if trace_if ();

  pc_trace_monitor #(.TRACE_DEPTH(16), .HALT_REPEAT(4), .CNT_W(32)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_pc_debug   (i_pc_debug),
    .i_insn_vld   (i_insn_vld),
    .o_retire_cnt (o_retire_cnt),
    .o_cycle_cnt  (o_cycle_cnt),
    .o_halted     (o_halted),
    .trace_if     (trace_if.master),
    .o_trace_level(o_trace_level),
    .o_trace_ovf  (o_trace_ovf)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy);
    @(negedge i_clk);
    i_insn_vld        = v;
    i_pc_debug        = pc;
    trace_if.trace_rdy = rdy;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_insn_vld         = 1'b0;
    i_pc_debug         = '0;
    trace_if.trace_rdy = 1'b0;
    i_reset            = 1'b0;
    @(negedge i_clk);
    i_reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    trace_if.trace_rdy = 1'b0;
    do_reset();
    check("rst_retire", o_retire_cnt, 0);
    check("rst_cycle", o_cycle_cnt, 0);
    check("rst_halted", {31'd0, o_halted}, 0);
    check("rst_vld", {31'd0, trace_if.trace_vld}, 0);
    check("rst_level", {27'd0, o_trace_level}, 0);
    check("rst_ovf", {31'd0, o_trace_ovf}, 0);

`ifdef PC_TRACE_DISCONT_ONLY_EN
    // Only the first retirement and the jump target are traced
    drive(1, 32'h00, 0); drive(1, 32'h04, 0); drive(1, 32'h08, 0);
    drive(1, 32'h40, 0); drive(1, 32'h44, 0); drive(0, 0, 0);
    check("disc_retire", o_retire_cnt, 5);
    check("disc_level", {27'd0, o_trace_level}, 2);
    check("disc_head0", trace_if.trace_pc, 32'h00);
    trace_if.trace_rdy = 1'b1;
    @(negedge i_clk);
    trace_if.trace_rdy = 1'b0;
    check("disc_head1", trace_if.trace_pc, 32'h40);
    check("disc_level1", {27'd0, o_trace_level}, 1);
`else
    // 1: ten sequential retirements, no draining
    for (int i = 0; i < 10; i++) drive(1, 32'(i * 4), 0);
    drive(0, 0, 0);
    check("t1_retire", o_retire_cnt, 10);
    check("t1_cycle", o_cycle_cnt, 10);
    check("t1_level", {27'd0, o_trace_level}, 10);
    check("t1_head", trace_if.trace_pc, 32'h00);
    check("t1_vld", {31'd0, trace_if.trace_vld}, 1);
    check("t1_halted", {31'd0, o_halted}, 0);

    // 2: overflow then full drain
    do_reset();
    for (int i = 0; i < 20; i++) drive(1, 32'(i * 4), 0);
    drive(0, 0, 0);
    check("t2_level", {27'd0, o_trace_level}, 16);
    check("t2_ovf", {31'd0, o_trace_ovf}, 1);
    check("t2_retire", o_retire_cnt, 20);
    for (int i = 0; i < 16; i++) begin
      check("t2_drain_vld", {31'd0, trace_if.trace_vld}, 1);
      check("t2_drain_pc", trace_if.trace_pc, 32'(i * 4));
      trace_if.trace_rdy = 1'b1;
      @(negedge i_clk);
    end
    trace_if.trace_rdy = 1'b0;
    check("t2_empty_vld", {31'd0, trace_if.trace_vld}, 0);
    check("t2_empty_level", {27'd0, o_trace_level}, 0);

    // 3: self-loop halt
    do_reset();
    drive(1, 32'h10, 0);
    for (int i = 0; i < 4; i++) drive(1, 32'h20, 0);
    check("t3_not_yet", {31'd0, o_halted}, 0);
    drive(0, 0, 0);
    check("t3_halted", {31'd0, o_halted}, 1);
    check("t3_retire", o_retire_cnt, 5);
    check("t3_cycle", o_cycle_cnt, 5);
    check("t3_level", {27'd0, o_trace_level}, 5);
    drive(1, 32'h30, 0); drive(1, 32'h34, 0); drive(0, 0, 0); drive(0, 0, 0);
    check("t3_frz_retire", o_retire_cnt, 5);
    check("t3_frz_cycle", o_cycle_cnt, 5);
    check("t3_frz_level", {27'd0, o_trace_level}, 5);
    check("t3_head", trace_if.trace_pc, 32'h10);
    drive(0, 0, 1); drive(0, 0, 0);
    check("t3_pop_level", {27'd0, o_trace_level}, 4);
    check("t3_pop_head", trace_if.trace_pc, 32'h20);

    // 4: full FIFO, simultaneous push and pop
    do_reset();
    for (int i = 0; i < 16; i++) drive(1, 32'(i * 4), 0);
    drive(0, 0, 0);
    check("t4_full", {27'd0, o_trace_level}, 16);
    check("t4_ovf0", {31'd0, o_trace_ovf}, 0);
    drive(1, 32'h100, 1); drive(0, 0, 0);
    check("t4_level", {27'd0, o_trace_level}, 16);
    check("t4_ovf", {31'd0, o_trace_ovf}, 0);
    check("t4_head", trace_if.trace_pc, 32'h04);

    // 5: asynchronous reset between edges
    do_reset();
    drive(1, 32'h00, 0); drive(1, 32'h04, 0); drive(1, 32'h08, 0); drive(0, 0, 0);
    check("t5_pre_level", {27'd0, o_trace_level}, 3);
    #2 i_reset = 1'b0;
    #1;
    check("t5_retire", o_retire_cnt, 0);
    check("t5_cycle", o_cycle_cnt, 0);
    check("t5_level", {27'd0, o_trace_level}, 0);
    check("t5_vld", {31'd0, trace_if.trace_vld}, 0);
    check("t5_pc", trace_if.trace_pc, 0);
    check("t5_halted", {31'd0, o_halted}, 0);
    check("t5_ovf", {31'd0, o_trace_ovf}, 0);
    @(negedge i_clk);
    i_reset = 1'b1;
    repeat (3) drive(0, 0, 0);
    check("t5_idle_cycle", o_cycle_cnt, 0);
    drive(1, 32'h80, 0); drive(0, 0, 0);
    check("t5_run_cycle", o_cycle_cnt, 1);
    check("t5_run_retire", o_retire_cnt, 1);
    check("t5_run_head", trace_if.trace_pc, 32'h80);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
